alu_cmd_sequencer: RTL

- Upstream/downstream wrapper stage for the 8-bit combinational ALU.
- Accepts operation commands over a valid/ready interface and queues them in a small FIFO.
- Drives the ALU operand and select inputs from registers, captures the ALU result one cycle later, and presents it with status flags over a valid/ready response interface.
- Holds an accumulator so chained operations can use the previous result as operand A.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU, its command sequencer and the top level:
// operand width, op encodings, sequencer FSM states and the queued command format.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_OR  = 3'b110,
    OP_AND = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // 20-bit queued command: {acc, op, b, a}
  typedef struct packed {
    logic              acc;
    op_t               op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command (valid/ready) and response (valid/ready) channels of the ALU sequencer.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [2:0]        cmd_op;
  logic              cmd_acc;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO; rdata shows the head entry
// whenever the FIFO is non-empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves the occupancy unchanged
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives the external combinational ALU from registers,
// captures its result one cycle later and returns it with zero/error flags.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_sel,
  input  logic [DATA_W-1:0]   alu_y,
  output logic [DATA_W-1:0]   acc
);

  state_t                 state;
  state_t                 state_nxt;
  cmd_t                   push_cmd;
  cmd_t                   head_cmd;
  logic                   push;
  logic                   pop;
  logic                   capture;
  logic                   rsp_done;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] queued_unused;

  assign push     = bus.cmd_valid && !full;
  assign push_cmd = '{acc: bus.cmd_acc, op: op_t'(bus.cmd_op), b: bus.cmd_b, a: bus.cmd_a};
  assign bus.cmd_ready = !full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (full),
    .empty (empty),
    .count (queued_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = HOLD;
      HOLD:    if (bus.rsp_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state)
      IDLE:  pop = !empty;
      ISSUE: capture = 1'b1;
      HOLD: begin
        rsp_done = bus.rsp_ready;
        pop      = bus.rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // Pop stage: operands and select registered toward the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= head_cmd.acc ? acc : head_cmd.a;
      alu_b   <= head_cmd.b;
      alu_sel <= head_cmd.op;
    end
  end

  // Capture stage: ALU result, flags and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      acc           <= '0;
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= alu_y;
      bus.rsp_zero  <= (alu_y == '0);
      bus.rsp_err   <= (alu_sel == OP_DIV) && (alu_b == '0);
      acc           <= alu_y;
    end else if (rsp_done) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule
